// File: rtl/fifo_pixel_unpacker_pkg.sv
// Shared packing definitions for the HDMI-side packer and the LCD-side unpacker.
// Three 32-bit words carry four 24-bit pixels, MSB first, R > G > B.
package fifo_pixel_unpacker_pkg;

    localparam int PIXEL_WIDTH = 24;
    localparam int WORD_WIDTH  = 32;
    localparam int BYTE_W      = 8;

    typedef enum logic [1:0] {
        PH_0 = 2'd0,
        PH_1 = 2'd1,
        PH_2 = 2'd2,
        PH_3 = 2'd3
    } phase_e;

    // Byte-lane LSB positions inside a packed word, lane 0 being the MSB byte.
    localparam int LANE0_LSB = 24;
    localparam int LANE1_LSB = 16;
    localparam int LANE2_LSB = 8;
    localparam int LANE3_LSB = 0;

    typedef struct packed {
        logic [PIXEL_WIDTH-1:0] pixel;
        logic [PIXEL_WIDTH-1:0] residual;
    } unpack_t;

    function automatic unpack_t unpack_step(input phase_e ph,
                                            input logic [PIXEL_WIDTH-1:0] res,
                                            input logic [WORD_WIDTH-1:0] w);
        unpack_t r;
        r = '0;
        case (ph)
            PH_0: begin
                r.pixel    = w[LANE2_LSB +: 3*BYTE_W];
                r.residual = {16'h0, w[LANE3_LSB +: BYTE_W]};
            end
            PH_1: begin
                r.pixel    = {res[BYTE_W-1:0], w[LANE1_LSB +: 2*BYTE_W]};
                r.residual = {8'h0, w[LANE3_LSB +: 2*BYTE_W]};
            end
            PH_2: begin
                r.pixel    = {res[2*BYTE_W-1:0], w[LANE0_LSB +: BYTE_W]};
                r.residual = w[LANE3_LSB +: 3*BYTE_W];
            end
            default: begin
                r.pixel    = res;
                r.residual = '0;
            end
        endcase
        return r;
    endfunction

    function automatic logic [PIXEL_WIDTH-1:0] rb_swap(input logic [PIXEL_WIDTH-1:0] p);
        return {p[BYTE_W-1:0], p[2*BYTE_W-1:BYTE_W], p[3*BYTE_W-1:2*BYTE_W]};
    endfunction

endpackage

// File: rtl/fifo_pixel_unpacker_word_buffer.sv
// Two-entry word buffer in front of the unpacker: issues FIFO reads, tracks the
// in-flight word and forwards it straight to the head when the buffer is empty.
module unpacker_word_buffer
    import fifo_pixel_unpacker_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [WORD_WIDTH-1:0] fifo_data,
    input  logic                  pop,
    output logic                  rd_req,
    output logic                  avail,
    output logic [WORD_WIDTH-1:0] head
);

    logic [1:0]            occ_q, occ_d;
    logic                  in_flight_q, in_flight_d;
    logic [WORD_WIDTH-1:0] buf0_q, buf0_d;
    logic [WORD_WIDTH-1:0] buf1_q, buf1_d;

    // Gated by reset so no word is pulled out of the FIFO only to be discarded.
    assign rd_req = rst_n && !fifo_empty &&
                    ((occ_q == 2'd0) || ((occ_q == 2'd1) && !in_flight_q));
    assign avail  = (occ_q != 2'd0) || in_flight_q;
    assign head   = (occ_q != 2'd0) ? buf0_q : fifo_data;

    always_comb begin
        occ_d       = occ_q;
        buf0_d      = buf0_q;
        buf1_d      = buf1_q;
        in_flight_d = rd_req;
        if (!(pop && (occ_q == 2'd0))) begin
            if (pop) begin
                buf0_d = buf1_q;
                occ_d  = occ_q - 2'd1;
            end
            if (in_flight_q) begin
                if (occ_d == 2'd0) begin
                    buf0_d = fifo_data;
                end else begin
                    buf1_d = fifo_data;
                end
                occ_d = occ_d + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            occ_q       <= 2'd0;
            in_flight_q <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
        end else begin
            occ_q       <= occ_d;
            in_flight_q <= in_flight_d;
            buf0_q      <= buf0_d;
            buf1_q      <= buf1_d;
        end
    end

endmodule

// File: rtl/fifo_pixel_unpacker.sv
// Re-forms 24-bit pixels from packed FIFO words for the LCD driver stage.
// Optional underrun counter port enabled by UNPACK_UNDERRUN_CNT_EN.
//
// phase | meaning
// PH_0  | next step consumes a word, pixel = w[31:8]
// PH_1  | next step consumes a word, pixel = {res[7:0], w[31:16]}
// PH_2  | next step consumes a word, pixel = {res[15:0], w[31:24]}
// PH_3  | next step uses the residual only
module fifo_pixel_unpacker #(
    parameter int PIXEL_WIDTH = fifo_pixel_unpacker_pkg::PIXEL_WIDTH,
    parameter int WORD_WIDTH  = fifo_pixel_unpacker_pkg::WORD_WIDTH,
    parameter bit SWAP_RB     = 1'b0
) (
    input  logic                   i_lcdClock,
    input  logic                   i_nReset,
    input  logic                   i_fifoEmpty,
    input  logic [WORD_WIDTH-1:0]  i_fifoData,
    output logic                   o_fifoRdReq,
    input  logic                   i_frameStart,
    output logic [PIXEL_WIDTH-1:0] o_pixel,
    output logic                   o_pixelValid,
`ifdef UNPACK_UNDERRUN_CNT_EN
    output logic [15:0]            o_underrunCount,
`endif
    input  logic                   i_pixelReady
);

    import fifo_pixel_unpacker_pkg::*;

    phase_e                 phase_q, phase_d;
    logic [PIXEL_WIDTH-1:0] res_q, res_d;
    logic [PIXEL_WIDTH-1:0] pixel_q, pixel_d;
    logic                   valid_q, valid_d;

    logic                   buf_avail;
    logic [WORD_WIDTH-1:0]  buf_head;
    logic                   step;
    logic                   pop;
    unpack_t                nxt;

    assign step = (!valid_q || i_pixelReady) && !i_frameStart &&
                  ((phase_q == PH_3) || buf_avail);
    assign pop  = step && (phase_q != PH_3);
    assign nxt  = unpack_step(phase_q, res_q, buf_head);

    unpacker_word_buffer u_word_buffer (
        .clk        (i_lcdClock),
        .rst_n      (i_nReset),
        .fifo_empty (i_fifoEmpty),
        .fifo_data  (i_fifoData),
        .pop        (pop),
        .rd_req     (o_fifoRdReq),
        .avail      (buf_avail),
        .head       (buf_head)
    );

    always_comb begin
        phase_d = phase_q;
        res_d   = res_q;
        pixel_d = pixel_q;
        valid_d = valid_q && !i_pixelReady;
        if (i_frameStart) begin
            phase_d = PH_0;
            res_d   = '0;
            valid_d = 1'b0;
        end else if (step) begin
            case (phase_q)
                PH_0:    phase_d = PH_1;
                PH_1:    phase_d = PH_2;
                PH_2:    phase_d = PH_3;
                default: phase_d = PH_0;
            endcase
            res_d   = nxt.residual;
            pixel_d = SWAP_RB ? rb_swap(nxt.pixel) : nxt.pixel;
            valid_d = 1'b1;
        end
    end

`ifdef UNPACK_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;

    always_comb begin
        ucnt_d = ucnt_q;
        if (i_frameStart) begin
            ucnt_d = '0;
        end else if (i_pixelReady && !valid_q && (ucnt_q != 16'hFFFF)) begin
            ucnt_d = ucnt_q + 16'd1;
        end
    end

    assign o_underrunCount = ucnt_q;
`endif

    always_ff @(posedge i_lcdClock) begin
        if (!i_nReset) begin
            phase_q <= PH_0;
            res_q   <= '0;
            pixel_q <= '0;
            valid_q <= 1'b0;
`ifdef UNPACK_UNDERRUN_CNT_EN
            ucnt_q  <= '0;
`endif
        end else begin
            phase_q <= phase_d;
            res_q   <= res_d;
            pixel_q <= pixel_d;
            valid_q <= valid_d;
`ifdef UNPACK_UNDERRUN_CNT_EN
            ucnt_q  <= ucnt_d;
`endif
        end
    end

    assign o_pixel      = pixel_q;
    assign o_pixelValid = valid_q;

endmodule

// File: tb/tb_fifo_pixel_unpacker.sv
// Scoreboard bench for fifo_pixel_unpacker (plain and SWAP_RB instances in lockstep).
// Underrun counter checks compile in when UNPACK_UNDERRUN_CNT_EN is defined.
module tb_fifo_pixel_unpacker;

    logic        clk = 1'b0;
    logic        n_reset, fifo_empty, frame_start, pixel_ready;
    logic [31:0] fifo_data;
    logic        rd_req, rd_req1, valid, valid1;
    logic [23:0] pixel, pixel1;
`ifdef UNPACK_UNDERRUN_CNT_EN
    logic [15:0] ucnt, ucnt1;
    int          ucnt_model = 0;
`endif

    always #5 clk = ~clk;

    fifo_pixel_unpacker #(.SWAP_RB(1'b0)) dut (
        .i_lcdClock(clk), .i_nReset(n_reset), .i_fifoEmpty(fifo_empty),
        .i_fifoData(fifo_data), .o_fifoRdReq(rd_req), .i_frameStart(frame_start),
        .o_pixel(pixel), .o_pixelValid(valid),
`ifdef UNPACK_UNDERRUN_CNT_EN
        .o_underrunCount(ucnt),
`endif
        .i_pixelReady(pixel_ready));

    fifo_pixel_unpacker #(.SWAP_RB(1'b1)) dut_swap (
        .i_lcdClock(clk), .i_nReset(n_reset), .i_fifoEmpty(fifo_empty),
        .i_fifoData(fifo_data), .o_fifoRdReq(rd_req1), .i_frameStart(frame_start),
        .o_pixel(pixel1), .o_pixelValid(valid1),
`ifdef UNPACK_UNDERRUN_CNT_EN
        .o_underrunCount(ucnt1),
`endif
        .i_pixelReady(pixel_ready));

    int          errors = 0, checks = 0;
    int          cyc = 0, reads = 0, acc = 0, last_acc_cyc = 0;
    bit          chk_occ = 0;
    logic [31:0] fifo_q[$];
    logic [23:0] exp_q[$];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic logic [23:0] swp(input logic [23:0] p);
        return {p[7:0], p[15:8], p[23:16]};
    endfunction

    function automatic int consumed(input int p);
        return p - p / 4;
    endfunction

    // FIFO model: read data appears the cycle after a sampled request.
    initial begin
        logic rd;
        fifo_empty = 1'b1;
        fifo_data  = '0;
        forever begin
            @(negedge clk);
            rd = rd_req;
            if (rd) check("rd_when_empty", {31'b0, fifo_empty}, 32'd0);
            @(posedge clk);
            #2;
            if (rd && fifo_q.size() > 0) begin
                fifo_data = fifo_q.pop_front();
                reads++;
            end
            fifo_empty = (fifo_q.size() == 0);
        end
    end

    // Monitor: acceptance compare, hold-stability and buffer-occupancy checks.
    initial begin
        bit          hold_pending = 0;
        logic [23:0] held = '0;
        logic [23:0] e;
        forever begin
            @(negedge clk);
            if (!n_reset) begin
                hold_pending = 0;
`ifdef UNPACK_UNDERRUN_CNT_EN
                ucnt_model = 0;
`endif
            end else begin
                if (chk_occ && rd_req) begin
                    check("rd_with_two_buffered", {31'b0, (reads - consumed(acc + int'(valid))) < 2}, 32'd1);
                    check("rd_req_swap_inst", {31'b0, rd_req1}, {31'b0, rd_req});
                end
                if (hold_pending && valid) check("hold_stable", {8'b0, pixel}, {8'b0, held});
                hold_pending = valid && !pixel_ready && !frame_start;
                held = pixel;
                if (valid && pixel_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_pixel: got %h expected none", pixel);
                    end else begin
                        e = exp_q.pop_front();
                        check("pixel", {8'b0, pixel}, {8'b0, e});
                        check("pixel_swap", {7'b0, valid1, pixel1}, {8'h01, swp(e)});
                    end
                    acc++;
                    last_acc_cyc = cyc;
                end
`ifdef UNPACK_UNDERRUN_CNT_EN
                if (frame_start) ucnt_model = 0;
                else if (pixel_ready && !valid && ucnt_model < 16'hFFFF) ucnt_model++;
`endif
            end
        end
    end

    task automatic push3(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        fifo_q.push_back(a); fifo_q.push_back(b); fifo_q.push_back(c);
    endtask

    task automatic exp4(input logic [23:0] a, input logic [23:0] b,
                        input logic [23:0] c, input logic [23:0] d);
        exp_q.push_back(a); exp_q.push_back(b); exp_q.push_back(c); exp_q.push_back(d);
    endtask

    task automatic wait_valid(input string name, input int max);
        for (int i = 0; i < max; i++) begin
            @(negedge clk);
            if (valid) break;
        end
        check(name, {31'b0, valid}, 32'd1);
    endtask

    task automatic drain(input string name, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) @(negedge clk);
        check(name, exp_q.size(), 32'd0);
    endtask

    task automatic pulse_frame();
        @(posedge clk); #1 frame_start = 1'b1;
        @(posedge clk); #1 frame_start = 1'b0;
    endtask

    initial begin
        int rd_cyc, val_cyc;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        n_reset = 1'b0; frame_start = 1'b0; pixel_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_valid", {31'b0, valid}, 32'd0);
        check("reset_pixel", {8'b0, pixel}, 32'd0);
        check("reset_rdreq", {31'b0, rd_req}, 32'd0);
        n_reset = 1'b1;

        // Basic stream with latency and throughput.
        reads = 0; acc = 0; chk_occ = 1; pixel_ready = 1'b1;
        push3(32'h11223344, 32'h55667788, 32'h99AABBCC);
        exp4(24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
        rd_cyc = -100;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rd_req) begin rd_cyc = cyc; break; end
        end
        wait_valid("first_valid_timeout", 20);
        val_cyc = cyc;
        check("first_latency", val_cyc - rd_cyc, 32'd2);
        check("swap_first_pixel", {8'b0, pixel1}, 32'h00332211);
        drain("drain_basic", 40);
        check("four_consecutive", last_acc_cyc - val_cyc, 32'd3);

        // Back-pressure 1,0,0,1.
        repeat (3) @(posedge clk);
        #1 reads = 0; acc = 0; pixel_ready = 1'b0;
        push3(32'h11223344, 32'h55667788, 32'h99AABBCC);
        exp4(24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
        wait_valid("stall_valid_timeout", 20);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1 pixel_ready = pat[i];
            @(negedge clk);
            if (i == 2) check("stall_hold_pixel", {7'b0, valid, pixel}, {8'h01, 24'h445566});
        end
        @(posedge clk); #1 pixel_ready = 1'b1;
        drain("drain_stall", 40);
        chk_occ = 0;

        // Underrun after the first word.
        pulse_frame();
        fifo_q.push_back(32'h11223344);
        exp_q.push_back(24'h112233);
        drain("drain_underrun_a", 20);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("underrun_no_valid", {31'b0, valid}, 32'd0);
        end
        @(posedge clk); #1;
        fifo_q.push_back(32'h55667788); fifo_q.push_back(32'h99AABBCC);
        exp_q.push_back(24'h445566); exp_q.push_back(24'h778899); exp_q.push_back(24'hAABBCC);
        drain("drain_underrun_b", 30);
        @(posedge clk); #1 pixel_ready = 1'b0;
        repeat (2) @(negedge clk);
`ifdef UNPACK_UNDERRUN_CNT_EN
        check("underrun_count", {16'b0, ucnt}, ucnt_model);
        check("underrun_count_swap", {16'b0, ucnt1}, ucnt_model);
`endif

        // Frame start in phase 2 with a pending pixel.
        push3(32'h11223344, 32'h55667788, 32'hDEADBEEF);
        exp_q.push_back(24'h112233);
        wait_valid("fs_valid_timeout", 20);
        @(posedge clk); #1 pixel_ready = 1'b1;
        @(posedge clk); #1 pixel_ready = 1'b0;
        @(negedge clk);
        check("phase2_pending", {7'b0, valid, pixel}, {8'h01, 24'h445566});
        pulse_frame();
        @(negedge clk);
        check("frame_drop_valid", {31'b0, valid}, 32'd0);
        exp_q.push_back(24'hDEADBE);
        @(posedge clk); #1 pixel_ready = 1'b1;
        drain("drain_frame", 20);
        pulse_frame();

        // Reset mid-stream.
        repeat (2) @(posedge clk);
        #1;
        push3(32'h11223344, 32'h55667788, 32'h99AABBCC);
        exp4(24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
        wait_valid("rst_valid_timeout", 20);
        @(posedge clk); #1 n_reset = 1'b0;
        @(negedge clk);
        check("rdreq_in_reset", {31'b0, rd_req}, 32'd0);
        @(posedge clk); #1 n_reset = 1'b1;
        fifo_q.delete();
        exp_q.delete();
        @(negedge clk);
        check("post_reset_outputs", {7'b0, valid, pixel}, 32'd0);
        @(posedge clk); #1;
        push3(32'h11223344, 32'h55667788, 32'h99AABBCC);
        exp4(24'h112233, 24'h445566, 24'h778899, 24'hAABBCC);
        drain("drain_after_reset", 40);

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fifo_pixel_unpacker.md
Name: fifo_pixel_unpacker

Overview:
Downstream consumer of the HDMI-side FIFO on the LCD clock domain. Reads the packed 32-bit words (MSB first, R > G > B, 3 words carry 4 pixels) and re-forms 24-bit RGB pixels. Presents the pixels to the LCD timing/driver stage over a valid/ready handshake. Re-aligns its packing phase on each frame start.

Parameters:
PIXEL_WIDTH, 24, output pixel width; fixed by the packing scheme, other values unsupported.
WORD_WIDTH, 32, FIFO read-data width; fixed.
SWAP_RB, 0, 1 = output {B,G,R} instead of {R,G,B}.

Ports:
i_lcdClock  input  1  LCD-domain clock; all logic on its rising edge.
i_nReset  input  1  reset; synchronous, active-low.
i_fifoEmpty  input  1  FIFO empty flag.
i_fifoData  input  32  FIFO read data; valid 1 cycle after o_fifoRdReq.
o_fifoRdReq  output  1  FIFO read request.
i_frameStart  input  1  1-cycle pulse from the LCD timing generator before the first pixel of a frame.
o_pixel  output  24  unpacked pixel.
o_pixelValid  output  1  o_pixel holds a valid pixel.
i_pixelReady  input  1  consumer accepts o_pixel this cycle.

Behaviour:
- Reset (i_nReset low at a clock edge): o_fifoRdReq=0, o_pixelValid=0, o_pixel=0, phase=0, residual=0, word buffer empty, in-flight flag=0.
- Word buffer: 2 entries. o_fifoRdReq = !i_fifoEmpty && (occupancy + in-flight) < 2. A word requested at cycle t is written to the buffer at t+1. Never read when empty; never overflow.
- Unpack phase (2 bits) and residual register (up to 24 bits). Each step produces one pixel:
  - phase 0: consume word w; pixel = w[31:8]; residual = w[7:0].
  - phase 1: consume w; pixel = {res[7:0], w[31:16]}; residual = w[15:0].
  - phase 2: consume w; pixel = {res[15:0], w[31:24]}; residual = w[23:0].
  - phase 3: consume no word; pixel = res[23:0].
  - Phase increments mod 4 after each step.
- A step fires when the output register is free or being emptied (!o_pixelValid || i_pixelReady) and, in phases 0-2, the buffer is non-empty. Phase 3 needs no word.
- o_pixel is registered. It holds stable while o_pixelValid && !i_pixelReady.
- Minimum latency: o_fifoRdReq at t, o_pixelValid at t+2.
- Sustained throughput: 1 pixel/cycle when the FIFO stays non-empty.
- Underrun: buffer empty in phases 0-2 gives o_pixelValid=0 (no bubble fill). Phase and residual are held until data arrives.
- i_frameStart: next cycle phase=0, residual=0, o_pixelValid=0. A pending unaccepted pixel is dropped. Buffered and in-flight words are kept: upstream is word-aligned at frame start because frame pixel count is a multiple of 4.
- i_frameStart in the same cycle as a step: frameStart wins and the step is not taken. No word is consumed that cycle.
- SWAP_RB=1: byte order of o_pixel is reversed at the output register only.

Optional Feature:
Macro UNPACK_UNDERRUN_CNT_EN.
- Defined: adds output o_underrunCount[15:0]. It increments on each cycle with i_pixelReady=1 && o_pixelValid=0 and saturates at 0xFFFF. It is cleared to 0 by reset and by i_frameStart.
- Undefined: the port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: PIXEL_WIDTH and WORD_WIDTH constants, the phase encoding constants, and the byte-lane slice constants for the 4-phase packing. The upstream packer uses the same package.
- Sub-module: unpacker_word_buffer (2-entry buffer plus read-request/in-flight tracking). The phase FSM and output register stay in the top module.

Test Plan:
- FIFO holds 0x11223344, 0x55667788, 0x99AABBCC; i_pixelReady=1 -> pixels 0x112233, 0x445566, 0x778899, 0xAABBCC on 4 consecutive cycles; first o_pixelValid 2 cycles after first o_fifoRdReq.
- Same data, i_pixelReady toggled 1,0,0,1 -> o_pixel held at 0x445566 through the stall; no pixel lost or duplicated; o_fifoRdReq never issued with 2 words buffered.
- i_fifoEmpty asserted after the first word -> 0x112233 emitted, then o_pixelValid=0 until 0x55667788 arrives, then 0x445566 resumes; with UNPACK_UNDERRUN_CNT_EN, count equals the stalled ready cycles.
- i_frameStart pulsed in phase 2 while a pixel is pending -> pending pixel dropped; the next word 0xDEADBEEF yields 0xDEADBE (phase 0).
- i_nReset low mid-stream for 1 cycle -> all outputs 0 next cycle; no o_fifoRdReq during reset; the stream restarts at phase 0.
- SWAP_RB=1 with word 0x11223344 -> first pixel 0x332211.
